// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   owner_e      - who owns the read data returning next cycle
//   DEF_*        - default address/data widths and starvation limit
package dmem_arb_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_MAX_WAIT = 4;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DBG  = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// dmem_arb_starve_cnt: counts consecutive cycles the debug requester is
// denied and raises force_dbg once the count reaches MAX_WAIT.
// Only instantiated when DMEM_ARB_STARVE_EN is defined.
//   Clk, Rst   - clock, synchronous active-high reset
//   dbg_req    - debug requester is asking this cycle
//   dbg_gnt    - debug requester was granted this cycle
//   force_dbg  - debug must win the current cycle
import dmem_arb_pkg::*;

module dmem_arb_starve_cnt #(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic Clk,
    input  logic Rst,
    input  logic dbg_req,
    input  logic dbg_gnt,
    output logic force_dbg
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    // A grant or a dropped request ends the streak; otherwise count up
    // and park at MAX_CNT until the debug grant happens.
    always_ff @(posedge Clk) begin
        if (Rst)
            wait_cnt <= 4'd0;
        else if (!dbg_req || dbg_gnt)
            wait_cnt <= 4'd0;
        else if (wait_cnt != MAX_CNT)
            wait_cnt <= wait_cnt + 4'd1;
    end

    assign force_dbg = (wait_cnt == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU MEM
// stage (default winner) and a debug/loader requester. Grants are
// combinational, so a granted access goes to memory the same cycle; read
// data returns one cycle later and is steered to whoever issued the read.
// Build option: define DMEM_ARB_STARVE_EN to add the debug anti-starvation
// counter; without it the CPU has strict priority.
//   cpu_req/we/addr/wdata  - CPU request;  cpu_gnt, cpu_stall
//   cpu_rvalid/rdata       - CPU read return
//   dbg_*                  - same set for the debug requester
//   mem_en/we/addr/wdata   - memory command;  mem_rdata - data, 1 cycle later
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be in 1..15");
    end

    logic   force_dbg;
    owner_e rd_owner;

`ifdef DMEM_ARB_STARVE_EN
    dmem_arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .Clk       (Clk),
        .Rst       (Rst),
        .dbg_req   (dbg_req),
        .dbg_gnt   (dbg_gnt),
        .force_dbg (force_dbg)
    );
`else
    assign force_dbg = 1'b0;
`endif

    // force_dbg comes straight from the counter, so in the cycle after the
    // streak saturates the CPU is held off even if debug has just dropped.
    always_comb begin
        cpu_gnt   = !Rst && cpu_req && !force_dbg;
        dbg_gnt   = !Rst && dbg_req && (!cpu_req || force_dbg);
        cpu_stall = !Rst && cpu_req && !cpu_gnt;
    end

    always_comb begin
        mem_en    = cpu_gnt || dbg_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
        end
    end

    // Grants are already gated by Rst, so a read issued while Rst is high
    // never gets an owner and never returns.
    always_ff @(posedge Clk) begin
        if (Rst)
            rd_owner <= NONE;
        else if (cpu_gnt && !cpu_we)
            rd_owner <= CPU;
        else if (dbg_gnt && !dbg_we)
            rd_owner <= DBG;
        else
            rd_owner <= NONE;
    end

    // Rst also masks a return already in flight when it asserts.
    always_comb begin
        cpu_rvalid = !Rst && (rd_owner == CPU);
        dbg_rvalid = !Rst && (rd_owner == DBG);
        cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
        dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
    end

endmodule
